param_updown_counter: RTL and testbench
=======================================

// Module: param_updown_counter
// PURPOSE
//   Parametrised up/down modulo counter with synchronous load, clock-enable prescaler and wrap flag.
//   Next generation of the team's fixed 4-bit counter: arbitrary width, programmable modulus, direction control.
//   Used as the general-purpose counter/timer primitive in datapath and control blocks.
// PARAMETERS
//   WIDTH     8               counter width in bits, >= 2
//   MOD_MAX   (1<<WIDTH)-1    largest count value; the counter runs over 0..MOD_MAX, 1 <= MOD_MAX <= 2^WIDTH-1
//   PRESCALE  1               enabled cycles per count step, >= 1; 1 = step on every enabled cycle
// PORTS
//   clock       in   1      rising-edge clock, single clock domain
//   reset       in   1      asynchronous, active-high reset
//   count       in   1      count enable; when low, the prescaler and the counter hold
//   up          in   1      direction: 1 = increment, 0 = decrement; sampled on each step
//   load        in   1      synchronous load strobe
//   load_value  in   WIDTH  value to load; values above MOD_MAX load as MOD_MAX
//   out         out  WIDTH  registered count value
//   wrap        out  1      registered 1-cycle pulse, high in the cycle after a wrap-around step
//   tc          out  1      combinational terminal-count flag: (up && out==MOD_MAX) || (!up && out==0)
// BEHAVIOUR
//   Reset (async, when reset is high): out=0, wrap=0, prescaler=0. Outputs are valid from the first edge after reset deasserts.
//   Priority on each rising edge: reset > load > step > hold.
//   load=1: out <= min(load_value, MOD_MAX), prescaler <= 0, wrap <= 0. Applies regardless of the count input.
//   Prescaler: internal counter of width clog2(PRESCALE), minimum 1 bit.
//     If count=1 and load=0, it increments; on reaching PRESCALE-1 it returns to 0 and a step occurs on that edge.
//     With PRESCALE=1, every cycle with count=1 and load=0 is a step.
//   Step when up=1: out==MOD_MAX -> out<=0 and wrap<=1; otherwise out<=out+1 and wrap<=0.
//   Step when up=0: out==0 -> out<=MOD_MAX and wrap<=1; otherwise out<=out-1 and wrap<=0.
//   Non-step cycle: out holds, wrap<=0. wrap is never high for 2 consecutive cycles unless 2 consecutive steps wrap.
//   Latency: out changes on the same edge that samples the step or load. tc follows out and up combinationally.
//   Arithmetic is modulo MOD_MAX+1. No intermediate value above MOD_MAX ever appears on out.
//   Changing direction mid-count takes effect on the next step; the prescaler phase is kept.
//   count deasserted mid-prescale: the prescaler holds its phase; it is not cleared.
//   Reset asserted mid-operation: immediate clear, independent of the clock; any pending step is discarded.
// CONFIGURATION
//   COUNTER_SATURATE_EN not defined (default): modulo wrap-around as described above.
//   COUNTER_SATURATE_EN defined:
//     Counting up, a step at out==MOD_MAX holds at MOD_MAX.
//     Counting down, a step at out==0 holds at 0.
//     wrap pulses for 1 cycle for each such blocked step and then means "saturated step".
//     All other behaviour (load, prescaler, tc, reset) is unchanged.
// TESTING
//   WIDTH=4, MOD_MAX=15, PRESCALE=1, up=1, count=1 for 17 cycles after reset
//     -> out 0,1..15,0,1; wrap high exactly 1 cycle, after 15->0.
//   WIDTH=4, MOD_MAX=9, up=0 from reset
//     -> out 0,9,8,7; wrap high after 0->9; tc high while out==0 with up=0.
//   load=1 with load_value=12 while count=1, MOD_MAX=9
//     -> out=9 next cycle; no step on that edge; wrap=0.
//   PRESCALE=3, count=1 continuously
//     -> out steps every 3rd cycle.
//   PRESCALE=3, count dropped for 2 cycles after the 1st enabled cycle
//     -> the next step comes after 2 more enabled cycles.
//   reset pulsed between clock edges at out=6
//     -> out=0 and wrap=0 immediately; counting resumes from 0 after release.
//   COUNTER_SATURATE_EN, WIDTH=4, out=15, up=1, 3 steps
//     -> out stays 15; wrap high for 3 cycles; then up=0 gives 14.

Source files
------------

// File: rtl/param_updown_counter_if.sv
// Control/status bundle of the up/down modulo counter; master drives controls, slave is the counter.
interface param_updown_counter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             count;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] out;
    logic             wrap;
    logic             tc;

    modport master (
        output count, up, load, load_value,
        input  out, wrap, tc
    );

    modport slave (
        input  count, up, load, load_value,
        output out, wrap, tc
    );
endinterface

// File: rtl/param_updown_counter.sv
// Up/down modulo counter with clamped sync load, prescaled count enable and wrap pulse (COUNTER_SATURATE_EN: saturate).
// Latency: out/wrap update on the edge that samples a load or step; tc is combinational from out and up.
// Backpressure: none; count low freezes both prescaler phase and count value.
module param_updown_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MOD_MAX  = (1 << WIDTH) - 1,
    parameter int unsigned PRESCALE = 1
) (
    input logic                   clock,
    input logic                   reset,
    param_updown_counter_if.slave bus
);
    localparam int unsigned      PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MOD_MAX);
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    pre_q, pre_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             wrap_q, wrap_d;
    logic             step;
    logic             at_top;
    logic             at_bot;

    always_comb begin
        at_top = (out_q == MAX_V);
        at_bot = (out_q == '0);
        step   = bus.count && !bus.load && (pre_q == PRE_LAST);
        pre_d  = pre_q;
        out_d  = out_q;
        wrap_d = 1'b0;

        if (bus.load) begin
            pre_d = '0;
            out_d = (bus.load_value > MAX_V) ? MAX_V : bus.load_value;
        end else if (bus.count) begin
            pre_d = step ? '0 : pre_q + 1'b1;
            if (step) begin
                if (bus.up) begin
                    if (at_top) begin
                        wrap_d = 1'b1;
`ifdef COUNTER_SATURATE_EN
                        out_d  = MAX_V;
`else
                        out_d  = '0;
`endif
                    end else begin
                        out_d = out_q + 1'b1;
                    end
                end else begin
                    if (at_bot) begin
                        wrap_d = 1'b1;
`ifdef COUNTER_SATURATE_EN
                        out_d  = '0;
`else
                        out_d  = MAX_V;
`endif
                    end else begin
                        out_d = out_q - 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_q  <= '0;
            out_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            out_q  <= out_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.wrap = wrap_q;
    assign bus.tc   = (bus.up && at_top) || (!bus.up && at_bot);
endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench: three counter instances (mod 16, mod 10, mod 10 with prescale 3) checked against hand-computed values.
module tb_param_updown_counter;
    logic clock;
    logic reset;
    int   tests;
    int   fails;

`ifdef COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    param_updown_counter_if #(.WIDTH(4)) a_if ();
    param_updown_counter_if #(.WIDTH(4)) b_if ();
    param_updown_counter_if #(.WIDTH(4)) c_if ();

    param_updown_counter #(.WIDTH(4), .MOD_MAX(15), .PRESCALE(1)) u_a (.clock(clock), .reset(reset), .bus(a_if));
    param_updown_counter #(.WIDTH(4), .MOD_MAX(9),  .PRESCALE(1)) u_b (.clock(clock), .reset(reset), .bus(b_if));
    param_updown_counter #(.WIDTH(4), .MOD_MAX(9),  .PRESCALE(3)) u_c (.clock(clock), .reset(reset), .bus(c_if));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_all();
        a_if.count = 0; a_if.up = 0; a_if.load = 0; a_if.load_value = 0;
        b_if.count = 0; b_if.up = 0; b_if.load = 0; b_if.load_value = 0;
        c_if.count = 0; c_if.up = 0; c_if.load = 0; c_if.load_value = 0;
    endtask

    task automatic do_reset();
        idle_all();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_all();
        reset = 1'b1;
        #1;
        tests++;
        if ({a_if.out, a_if.wrap, b_if.out, b_if.wrap, c_if.out, c_if.wrap} !== 15'd0) begin
            fails++;
            $display("FAIL reset_state a=%0d/%0b b=%0d/%0b c=%0d/%0b expected all 0",
                     a_if.out, a_if.wrap, b_if.out, b_if.wrap, c_if.out, c_if.wrap);
        end
        tick();
        reset = 1'b0;
        tick();
        tests++;
        if ({a_if.out, a_if.wrap, a_if.tc} !== 6'b0000_0_1) begin
            fails++;
            $display("FAIL reset_hold out=%0d wrap=%0b tc=%0b expected 0/0/1", a_if.out, a_if.wrap, a_if.tc);
        end
    endtask

    task automatic test_up_wrap();
        logic [3:0] eo;
        logic       ew, et;
        do_reset();
        a_if.up = 1; a_if.count = 1;
        #1;
        tests++;
        if (a_if.tc !== 1'b0) begin
            fails++;
            $display("FAIL up_tc_at0 tc=%0b expected 0", a_if.tc);
        end
        for (int k = 1; k <= 17; k++) begin
            tick();
            eo = SAT ? ((k >= 15) ? 4'd15 : 4'(k)) : 4'(k % 16);
            ew = SAT ? (k >= 16) : (k == 16);
            et = (eo == 4'd15);
            tests++;
            if ({a_if.out, a_if.wrap, a_if.tc} !== {eo, ew, et}) begin
                fails++;
                $display("FAIL up_wrap step %0d out=%0d wrap=%0b tc=%0b expected %0d/%0b/%0b",
                         k, a_if.out, a_if.wrap, a_if.tc, eo, ew, et);
            end
        end
    endtask

    task automatic test_down();
        logic [3:0] eo;
        logic       ew, et;
        do_reset();
        b_if.up = 0;
        #1;
        tests++;
        if ({b_if.out, b_if.tc} !== 5'b0000_1) begin
            fails++;
            $display("FAIL down_tc_at0 out=%0d tc=%0b expected 0/1", b_if.out, b_if.tc);
        end
        b_if.count = 1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            eo = SAT ? 4'd0 : 4'(10 - k);
            ew = SAT ? 1'b1 : (k == 1);
            et = (eo == 4'd0);
            tests++;
            if ({b_if.out, b_if.wrap, b_if.tc} !== {eo, ew, et}) begin
                fails++;
                $display("FAIL down step %0d out=%0d wrap=%0b tc=%0b expected %0d/%0b/%0b",
                         k, b_if.out, b_if.wrap, b_if.tc, eo, ew, et);
            end
        end
        b_if.count = 0;
        tick();
        tests++;
        if ({b_if.out, b_if.wrap} !== {(SAT ? 4'd0 : 4'd7), 1'b0}) begin
            fails++;
            $display("FAIL down_hold out=%0d wrap=%0b expected %0d/0", b_if.out, b_if.wrap, SAT ? 0 : 7);
        end
    endtask

    task automatic test_load_clamp();
        b_if.count = 1; b_if.up = 1; b_if.load = 1; b_if.load_value = 4'd12;
        tick();
        tests++;
        if ({b_if.out, b_if.wrap, b_if.tc} !== {4'd9, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL load_clamp out=%0d wrap=%0b tc=%0b expected 9/0/1", b_if.out, b_if.wrap, b_if.tc);
        end
        b_if.load_value = 4'd5;
        tick();
        tests++;
        if (b_if.out !== 4'd5) begin
            fails++;
            $display("FAIL load_plain out=%0d expected 5", b_if.out);
        end
        b_if.count = 0; b_if.load_value = 4'd9;
        tick();
        tests++;
        if (b_if.out !== 4'd9) begin
            fails++;
            $display("FAIL load_no_count out=%0d expected 9", b_if.out);
        end
        b_if.load = 0; b_if.count = 1;
        tick();
        tests++;
        if ({b_if.out, b_if.wrap} !== {(SAT ? 4'd9 : 4'd0), 1'b1}) begin
            fails++;
            $display("FAIL wrap_at_9 out=%0d wrap=%0b expected %0d/1", b_if.out, b_if.wrap, SAT ? 9 : 0);
        end
        b_if.load = 1; b_if.load_value = 4'd3;
        tick();
        tests++;
        if ({b_if.out, b_if.wrap} !== {4'd3, 1'b0}) begin
            fails++;
            $display("FAIL load_clears_wrap out=%0d wrap=%0b expected 3/0", b_if.out, b_if.wrap);
        end
        b_if.load = 0; b_if.count = 0;
    endtask

    task automatic test_prescale();
        do_reset();
        c_if.count = 1; c_if.up = 1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            tests++;
            if ({c_if.out, c_if.wrap} !== {4'(k / 3), 1'b0}) begin
                fails++;
                $display("FAIL prescale cycle %0d out=%0d wrap=%0b expected %0d/0", k, c_if.out, c_if.wrap, k / 3);
            end
        end
    endtask

    task automatic test_prescale_gap();
        logic [3:0] exp_seq [5];
        logic       en_seq  [5];
        exp_seq = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
        en_seq  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        c_if.up = 1;
        for (int k = 0; k < 5; k++) begin
            c_if.count = en_seq[k];
            tick();
            tests++;
            if (c_if.out !== exp_seq[k]) begin
                fails++;
                $display("FAIL prescale_gap cycle %0d out=%0d expected %0d", k, c_if.out, exp_seq[k]);
            end
        end
        c_if.count = 0;
    endtask

    task automatic test_direction_change();
        logic [3:0] exp_a [3];
        logic       up_a  [3];
        exp_a = '{4'd6, 4'd5, 4'd4};
        up_a  = '{1'b1, 1'b0, 1'b0};
        do_reset();
        a_if.load = 1; a_if.load_value = 4'd5; a_if.count = 1;
        tick();
        a_if.load = 0;
        for (int k = 0; k < 3; k++) begin
            a_if.up = up_a[k];
            tick();
            tests++;
            if (a_if.out !== exp_a[k]) begin
                fails++;
                $display("FAIL dir_change_a step %0d out=%0d expected %0d", k, a_if.out, exp_a[k]);
            end
        end
        a_if.count = 0;
        // Load mid-phase must restart the prescaler; direction flips on the third enabled cycle.
        c_if.count = 1; c_if.up = 1;
        tick();
        c_if.load = 1; c_if.load_value = 4'd5;
        tick();
        c_if.load = 0;
        tick();
        tick();
        tests++;
        if (c_if.out !== 4'd5) begin
            fails++;
            $display("FAIL prescale_load_phase out=%0d expected 5", c_if.out);
        end
        c_if.up = 0;
        tick();
        tests++;
        if (c_if.out !== 4'd4) begin
            fails++;
            $display("FAIL prescale_dir_change out=%0d expected 4", c_if.out);
        end
        c_if.count = 0;
    endtask

    task automatic test_async_reset();
        do_reset();
        a_if.count = 1; a_if.up = 1;
        repeat (6) tick();
        tests++;
        if (a_if.out !== 4'd6) begin
            fails++;
            $display("FAIL async_pre out=%0d expected 6", a_if.out);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({a_if.out, a_if.wrap} !== 5'd0) begin
            fails++;
            $display("FAIL async_clear out=%0d wrap=%0b expected 0/0", a_if.out, a_if.wrap);
        end
        #1 reset = 1'b0;
        tick();
        tests++;
        if (a_if.out !== 4'd1) begin
            fails++;
            $display("FAIL async_resume out=%0d expected 1", a_if.out);
        end
        a_if.count = 0; a_if.load = 1; a_if.load_value = 4'd15;
        tick();
        a_if.load = 0; a_if.count = 1;
        tick();
        a_if.count = 0;
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({a_if.out, a_if.wrap} !== 5'd0) begin
            fails++;
            $display("FAIL async_clear_wrap out=%0d wrap=%0b expected 0/0", a_if.out, a_if.wrap);
        end
        #1 reset = 1'b0;
    endtask

    task automatic test_saturate();
        logic [3:0] eo;
        logic       ew;
        do_reset();
        a_if.load = 1; a_if.load_value = 4'd15; a_if.up = 1;
        tick();
        a_if.load = 0; a_if.count = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            eo = SAT ? 4'd15 : 4'(k);
            ew = SAT ? 1'b1 : (k == 0);
            tests++;
            if ({a_if.out, a_if.wrap} !== {eo, ew}) begin
                fails++;
                $display("FAIL top_step %0d out=%0d wrap=%0b expected %0d/%0b", k, a_if.out, a_if.wrap, eo, ew);
            end
        end
        a_if.up = 0;
        tick();
        tests++;
        if ({a_if.out, a_if.wrap} !== {(SAT ? 4'd14 : 4'd1), 1'b0}) begin
            fails++;
            $display("FAIL top_reverse out=%0d wrap=%0b expected %0d/0", a_if.out, a_if.wrap, SAT ? 14 : 1);
        end
        a_if.count = 0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        idle_all();
        test_reset();
        test_up_wrap();
        test_down();
        test_load_clamp();
        test_prescale();
        test_prescale_gap();
        test_direction_change();
        test_async_reset();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
